// File: rtl/matrix_load_sequencer.sv
// Streams scalar elements into an MxN element-addressed matrix store,
// row-major or column-major, with an optional zero sweep beforehand.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               begin a sequence (sampled only when idle)
//   clear               with start: zero every element before loading
//   transpose           with start: 0 = row-major, 1 = column-major fill
//   in_value/valid      streamed element, accepted when in_ready is high
//   in_ready            high while loading (combinational)
//   mat_row/col/value   registered store address and data, zero-extended
//   mat_write           one-cycle store write strobe
//   busy                sequence in progress (clearing or loading)
//   done                one-cycle pulse with the final element write
module matrix_load_sequencer #(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int nBits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic             transpose,
    input  logic [nBits-1:0] in_value,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [nBits-1:0] mat_row,
    output logic [nBits-1:0] mat_col,
    output logic [nBits-1:0] mat_value,
    output logic             mat_write,
    output logic             busy,
    output logic             done
);

    localparam int MAXD = (M > N) ? M : N;
    localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    localparam logic [CW-1:0] LAST_R = CW'(M - 1);
    localparam logic [CW-1:0] LAST_C = CW'(N - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] ZERO   = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          tr_q;

    logic          row_end;
    logic          col_end;
    logic          at_last;
    logic          col_major;
    logic [CW-1:0] next_row;
    logic [CW-1:0] next_col;

    assign in_ready = (state == LOAD);

    // Both fill orders finish on (M-1, N-1), so one last-element test
    // serves every mode.  Each counter wraps explicitly at its limit so
    // no value beyond M-1 / N-1 is ever produced, even for 1-wide sizes.
    always_comb begin
        row_end   = (row == LAST_R);
        col_end   = (col == LAST_C);
        at_last   = row_end && col_end;
        col_major = tr_q && (state == LOAD);
        next_row  = row;
        next_col  = col;
        if (col_major) begin
            next_row = row_end ? ZERO : row + ONE;
            if (row_end) begin
                next_col = col_end ? ZERO : col + ONE;
            end
        end else begin
            next_col = col_end ? ZERO : col + ONE;
            if (col_end) begin
                next_row = row_end ? ZERO : row + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            tr_q      <= 1'b0;
            mat_row   <= '0;
            mat_col   <= '0;
            mat_value <= '0;
            mat_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mat_write <= 1'b0;
                    done      <= 1'b0;
                    row       <= '0;
                    col       <= '0;
                    if (start) begin
                        tr_q <= transpose;
                        busy <= 1'b1;
                        if (clear) begin
                            // Present the (0,0) zero write on entry so
                            // the strobe is high for every CLEAR cycle.
                            state     <= CLEAR;
                            mat_write <= 1'b1;
                            mat_value <= '0;
                            mat_row   <= '0;
                            mat_col   <= '0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end

                CLEAR: begin
                    // row/col name the element whose zero write is
                    // currently on the outputs.
                    if (at_last) begin
                        state     <= LOAD;
                        row       <= '0;
                        col       <= '0;
                        mat_write <= 1'b0;
                    end else begin
                        row       <= next_row;
                        col       <= next_col;
                        mat_row   <= nBits'(next_row);
                        mat_col   <= nBits'(next_col);
                        mat_value <= '0;
                        mat_write <= 1'b1;
                    end
                end

                LOAD: begin
                    if (in_valid) begin
                        mat_write <= 1'b1;
                        mat_value <= in_value;
                        mat_row   <= nBits'(row);
                        mat_col   <= nBits'(col);
                        if (at_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            row   <= '0;
                            col   <= '0;
                        end else begin
                            row <= next_row;
                            col <= next_col;
                        end
                    end else begin
                        mat_write <= 1'b0;
                    end
                end

                DONE: begin
                    mat_write <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    mat_write <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/matrix_load_sequencer.md
Name: matrix_load_sequencer

Overview:
Controller that fills the element-by-element matrix store from a streamed source. It accepts scalar values over a valid/ready handshake and drives the store's row, column, value and write inputs in row-major or column-major (transpose) order. It can optionally sweep zeros into every element first. It sits between the stream front-end and the matrix register bank that feeds the pseudo-inverse datapath.

Parameters:
M, 4, number of matrix rows (>=1)
N, 4, number of matrix columns (>=1)
nBits, 32, data width and width of the row/column index outputs

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a load sequence; sampled only in IDLE
clear  input  1  with start: zero all M*N elements before loading
transpose  input  1  with start: 0 = row-major fill, 1 = column-major fill
in_value  input  nBits  streamed element value
in_valid  input  1  in_value is valid
in_ready  output  1  sequencer accepts an element this cycle
mat_row  output  nBits  row index to store, zero-extended
mat_col  output  nBits  column index to store, zero-extended
mat_value  output  nBits  value to store
mat_write  output  1  one-cycle write strobe to store
busy  output  1  sequence in progress (CLEAR or LOAD)
done  output  1  one-cycle pulse: final element written

Behaviour:
- Reset (reset=1 at clk edge): state IDLE; mat_row, mat_col, mat_value, mat_write, busy and done all 0; in_ready 0; internal counters 0. Reset overrides every other input.
- All outputs are registered, except in_ready, which is combinational: in_ready = (state==LOAD).
- States: IDLE, CLEAR, LOAD, DONE.
- IDLE: on start=1, latch clear and transpose, zero the counters, and go to CLEAR if clear=1, else LOAD. With start=0, stay in IDLE.
- start asserted in any other state is ignored and not queued.
- CLEAR: one element per cycle, row-major, for exactly M*N cycles. Each cycle mat_write=1, mat_value=0 and mat_row/mat_col are the current index. After the (M-1,N-1) write, go to LOAD with counters reset to 0. in_ready=0 throughout.
- LOAD: a transfer occurs on an edge with in_valid=1 and in_ready=1.
  - The cycle after a transfer: mat_write=1, mat_value=in_value, mat_row/mat_col = index at transfer time. Latency is 1 cycle.
  - Cycles without a transfer: mat_write=0, counters hold, and mat_row/mat_col/mat_value hold their last values.
- Index order:
  - transpose=0: col increments first, wrapping at N-1 to 0 and incrementing row.
  - transpose=1: row increments first, wrapping at M-1 to 0 and incrementing col.
  - Element k (0-based) goes to (k/N, k%N) for transpose=0, and to (k%M, k/M) for transpose=1.
- Transfer of element M*N-1 moves the state to DONE. In DONE, mat_write=1 for that last element and done=1 in the same cycle; in_ready=0. Next cycle: IDLE.
- busy=1 exactly while state is CLEAR or LOAD.
- Reset mid-sequence returns to IDLE on that edge with mat_write=0. Elements already written in the store are not touched.
- Degenerate sizes: M=1 or N=1 (including 1x1) are legal; wrap logic must not overflow. Counter width is clog2(max(M,N)), minimum 1 bit.
- Zero-latency tie-off: in_valid held high gives one write per cycle, M*N consecutive mat_write cycles with no bubbles.

Test Plan:
- Reset then row-major load, M=N=4: start=1, clear=0, transpose=0, in_valid held high, values 1..16.
  - Required: 16 consecutive mat_write pulses, (0,0)=1, (0,1)=2, …, (3,3)=16.
  - done=1 on the 16th write cycle; busy high for 16 cycles; IDLE next.
- Transpose load, M=2, N=3: values 10..15.
  - Required: writes to (0,0)=10, (1,0)=11, (0,1)=12, (1,1)=13, (0,2)=14, (1,2)=15.
- Clear then load, M=N=4, clear=1.
  - Required: 16 writes of 0 in row-major order, in_ready=0 throughout, then LOAD.
  - First data write occurs only after the 16th clear write.
- Bubbled stream: in_valid pattern 1,0,0,1,1,0,…
  - Required: mat_write only the cycle after each accepted element; indices advance only on transfers.
  - start pulsed during LOAD is ignored.
- Reset mid-LOAD after 5 transfers: reset=1 for one cycle.
  - Required: next cycle IDLE, mat_write=0, busy=0, done never pulses.
  - A fresh start restarts at (0,0).
- 1x1 matrix, clear=1.
  - Required: one clear write to (0,0), one data write to (0,0), done pulse, back to IDLE with no index overflow.
